// File: rtl/mem_io_responder_pkg.sv
// ============================================================================
// Module  : mem_io_responder_pkg
// Purpose : Shared bus encodings and widths for the memory-side responder.
//           Holds the read/write encoding, the bus widths and the default
//           byte address of the memory-mapped output port.
// Ports   : none (package)
// Config  : MEM_IO_OVERFLOW_STAT_EN is consumed by mem_io_responder, not here.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_io_responder_pkg;

  // Bus direction encoding shared with the memory controller.
  localparam logic c_READ  = 1'b0;
  localparam logic c_WRITE = 1'b1;

  // Bus widths.
  localparam int MEM_DATA_BUS = 8;
  localparam int ADDR_BUS     = 32;

  // Default byte address of the output port.
  localparam logic [ADDR_BUS-1:0] c_IO_ADDR_DEFAULT = 32'h0003_0000;

endpackage

`default_nettype wire

// File: rtl/mem_io_responder_fifo.sv
// ============================================================================
// Module  : tx_byte_fifo
// Purpose : Small power-of-two byte FIFO for the TX side of the output port.
//           Head data is combinational from the read pointer; the
//           almost-full flag is registered from the next-cycle count.
// Ports   : clk, rst_n         - clock, asynchronous active-low reset
//           i_push, i_data     - write request and byte
//           i_pop              - read request (ignored when empty)
//           o_head             - byte at the read pointer
//           o_count            - current occupancy, 0..DEPTH
//           o_full             - occupancy equals DEPTH
//           o_almost_full      - registered, next occupancy >= DEPTH-1
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_byte_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_ALMOST = CNT_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_almost_full;

  logic              w_pop;
  logic              w_push;
  logic [CNT_W-1:0]  w_next_count;

  assign w_pop  = i_pop && (r_count != '0);
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign w_push = i_push && ((r_count < c_DEPTH) || w_pop);

  always_comb begin
    w_next_count = r_count;
    case ({w_push, w_pop})
      2'b10:   w_next_count = r_count + CNT_W'(1);
      2'b01:   w_next_count = r_count - CNT_W'(1);
      default: w_next_count = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count       <= w_next_count;
      r_almost_full <= (w_next_count >= c_ALMOST);
    end
  end

  assign o_head        = r_mem[r_rd_ptr];
  assign o_count       = r_count;
  assign o_full        = (r_count == c_DEPTH);
  assign o_almost_full = r_almost_full;

endmodule

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ============================================================================
// Module  : mem_io_responder
// Purpose : Memory-side responder on the byte-wide memory bus. Serves a
//           byte-addressed RAM and a memory-mapped output port at IO_ADDR
//           whose writes are queued in a paced TX FIFO.
// Ports   : clk, rst_n         - clock, asynchronous active-low reset
//           rdy                - global ready, freezes the bus side when low
//           iMEM_rw            - c_READ / c_WRITE
//           iMEM_addr          - byte address
//           iMEM_dt            - write byte
//           oMEM_dt            - registered read byte
//           oIO_buffer_full    - TX FIFO within one entry of full
//           oTX_valid/oTX_data - TX head handshake and byte
//           iTX_ready          - consumer accepts head byte
//           oIO_overflow       - sticky drop flag      (MEM_IO_OVERFLOW_STAT_EN)
//           oIO_drop_cnt       - saturating drop count (MEM_IO_OVERFLOW_STAT_EN)
// Config  : define MEM_IO_OVERFLOW_STAT_EN to add the overflow statistics.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 17,
  parameter int                  FIFO_DEPTH = 8,
  parameter logic [ADDR_BUS-1:0] IO_ADDR    = c_IO_ADDR_DEFAULT,
  parameter int                  DRAIN_DIV  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    iMEM_rw,
  input  logic [ADDR_BUS-1:0]     iMEM_addr,
  input  logic [MEM_DATA_BUS-1:0] iMEM_dt,
  output logic [MEM_DATA_BUS-1:0] oMEM_dt,
  output logic                    oIO_buffer_full,
  output logic                    oTX_valid,
  output logic [MEM_DATA_BUS-1:0] oTX_data,
  input  logic                    iTX_ready
`ifdef MEM_IO_OVERFLOW_STAT_EN
  ,
  output logic                    oIO_overflow,
  output logic [15:0]             oIO_drop_cnt
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PACE_W = $clog2(DRAIN_DIV + 1);
  localparam logic [PACE_W-1:0] c_PACE_RELOAD = PACE_W'(DRAIN_DIV - 1);

  logic [MEM_DATA_BUS-1:0] r_ram [2**ADDR_WIDTH];
  logic [MEM_DATA_BUS-1:0] r_mem_dt;
  logic [PACE_W-1:0]       r_pace;

  logic                    w_is_io;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_ram_wr;
  logic                    w_io_wr;
  logic                    w_push;
  logic                    w_tx_valid;
  logic                    w_tx_pop;
  logic [CNT_W-1:0]        w_fifo_count;
  logic                    w_fifo_full;
  logic                    w_fifo_afull;
  logic [MEM_DATA_BUS-1:0] w_fifo_head;

  // Address decode; upper RAM address bits are ignored so the RAM aliases.
  assign w_is_io  = (iMEM_addr == IO_ADDR);
  assign w_idx    = iMEM_addr[ADDR_WIDTH-1:0];
  assign w_ram_wr = rdy && (iMEM_rw == c_WRITE) && !w_is_io;
  assign w_io_wr  = rdy && (iMEM_rw == c_WRITE) && w_is_io;

  // Drain is independent of rdy; pacing blocks valid until the counter expires.
  assign w_tx_valid = (w_fifo_count != '0) && (r_pace == '0);
  assign w_tx_pop   = w_tx_valid && iTX_ready;
  assign w_push     = w_io_wr && (!w_fifo_full || w_tx_pop);

  tx_byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (MEM_DATA_BUS)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (w_push),
    .i_data        (iMEM_dt),
    .i_pop         (w_tx_pop),
    .o_head        (w_fifo_head),
    .o_count       (w_fifo_count),
    .o_full        (w_fifo_full),
    .o_almost_full (w_fifo_afull)
  );

  // RAM storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      r_ram[w_idx] <= iMEM_dt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_dt <= '0;
    end else if (rdy) begin
      if (iMEM_rw == c_READ) begin
        r_mem_dt <= w_is_io ? '0 : r_ram[w_idx];
      end else begin
        r_mem_dt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pace <= '0;
    end else if (w_tx_pop) begin
      r_pace <= c_PACE_RELOAD;
    end else if (r_pace != '0) begin
      r_pace <= r_pace - PACE_W'(1);
    end
  end

`ifdef MEM_IO_OVERFLOW_STAT_EN
  logic        w_drop;
  logic        r_overflow;
  logic [15:0] r_drop_cnt;

  assign w_drop = w_io_wr && !w_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign oIO_overflow = r_overflow;
  assign oIO_drop_cnt = r_drop_cnt;
`endif

  assign oMEM_dt         = r_mem_dt;
  assign oIO_buffer_full = w_fifo_afull;
  assign oTX_valid       = w_tx_valid;
  assign oTX_data        = w_fifo_head;

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// ============================================================================
// Module  : tb_mem_io_responder
// Purpose : Directed self-checking bench for mem_io_responder.
// Config  : honours MEM_IO_OVERFLOW_STAT_EN for the statistics ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_io_responder;
  import mem_io_responder_pkg::*;

  localparam logic [31:0] c_IO = 32'h0003_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        rw;
  logic [31:0] addr;
  logic [7:0]  dt_in;
  logic [7:0]  dt_out;
  logic        buf_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
`ifdef MEM_IO_OVERFLOW_STAT_EN
  logic        overflow;
  logic [15:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_io_responder #(
    .ADDR_WIDTH (17),
    .FIFO_DEPTH (8),
    .IO_ADDR    (c_IO),
    .DRAIN_DIV  (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdy             (rdy),
    .iMEM_rw         (rw),
    .iMEM_addr       (addr),
    .iMEM_dt         (dt_in),
    .oMEM_dt         (dt_out),
    .oIO_buffer_full (buf_full),
    .oTX_valid       (tx_valid),
    .oTX_data        (tx_data),
    .iTX_ready       (tx_ready)
`ifdef MEM_IO_OVERFLOW_STAT_EN
    ,
    .oIO_overflow    (overflow),
    .oIO_drop_cnt    (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic [7:0] d);
    rw    = r;
    addr  = a;
    dt_in = d;
  endtask

  task automatic idle();
    drive(c_READ, 32'h0000_0100, 8'h00);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!tx_valid && k < 12) begin
      tick();
      k++;
    end
    if (!tx_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [7:0] exp_drain [8];

  initial begin
    rst_n    = 1'b0;
    rdy      = 1'b1;
    tx_ready = 1'b0;
    idle();
    tick();
    tick();
    check("rst_mem_dt", dt_out, 32'h0);
    check("rst_tx_valid", tx_valid, 32'h0);
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_buf_full", buf_full, 32'h0);
    rst_n = 1'b1;

    // Plain write then read, with data one cycle after the read address.
    drive(c_WRITE, 32'h0001_0000, 8'h5A); tick();
    drive(c_WRITE, 32'h0000_0020, 8'h77); tick();
    drive(c_WRITE, 32'h0000_0010, 8'hA5); tick();
    check("wr_cycle_mem_dt", dt_out, 32'h0);
    drive(c_READ, 32'h0000_0010, 8'h00); tick();
    check("rd_a5", dt_out, 32'hA5);

    // Upper address bits alias onto the RAM.
    drive(c_WRITE, 32'h0002_0010, 8'h3C); tick();
    drive(c_READ, 32'h0000_0010, 8'h00); tick();
    check("rd_wrap", dt_out, 32'h3C);

    // rdy low freezes output, RAM and FIFO.
    rdy = 1'b0;
    drive(c_WRITE, 32'h0000_0010, 8'hFF); tick();
    check("rdy0_hold", dt_out, 32'h3C);
    drive(c_WRITE, c_IO, 8'hEE); tick();
    check("rdy0_no_push", tx_valid, 32'h0);
    rdy = 1'b1;
    drive(c_READ, 32'h0000_0010, 8'h00); tick();
    check("rdy0_no_ram_wr", dt_out, 32'h3C);

    // IO read returns zero.
    drive(c_READ, c_IO, 8'h00); tick();
    check("io_read_zero", dt_out, 32'h0);

    // Paced drain of "Hi".
    tx_ready = 1'b1;
    drive(c_WRITE, c_IO, 8'h48); tick();
    check("tx_h_valid", tx_valid, 32'h1);
    check("tx_h_data", tx_data, 32'h48);
    drive(c_WRITE, c_IO, 8'h69); tick();
    check("pace_block1", tx_valid, 32'h0);
    idle(); tick();
    check("pace_block2", tx_valid, 32'h0);
    tick();
    check("pace_block3", tx_valid, 32'h0);
    tick();
    check("tx_i_valid", tx_valid, 32'h1);
    check("tx_i_data", tx_data, 32'h69);
    tick();
    check("tx_empty", tx_valid, 32'h0);
    drive(c_READ, 32'h0001_0000, 8'h00); tick();
    check("io_no_ram", dt_out, 32'h5A);

    // Fill to the almost-full mark, then full, then overflow.
    tx_ready = 1'b0;
    idle();
    for (int k = 0; k < 5; k++) tick();
    for (int k = 0; k < 9; k++) begin
      drive(c_WRITE, c_IO, 8'(8'h10 + k));
      tick();
      if (k == 5) check("full_after6", buf_full, 32'h0);
      if (k == 6) check("full_after7", buf_full, 32'h1);
    end
    idle();
    check("full_head_valid", tx_valid, 32'h1);
    check("full_head_data", tx_data, 32'h10);
    check("full_flag_8", buf_full, 32'h1);
`ifdef MEM_IO_OVERFLOW_STAT_EN
    check("ovf_flag", overflow, 32'h1);
    check("ovf_cnt", drop_cnt, 32'h1);
`endif

    // Push and pop together at full: accepted.
    tx_ready = 1'b1;
    drive(c_WRITE, c_IO, 8'h19); tick();
    idle();
    check("pp_full_flag", buf_full, 32'h1);
    check("pp_paced", tx_valid, 32'h0);
`ifdef MEM_IO_OVERFLOW_STAT_EN
    check("pp_no_drop", drop_cnt, 32'h1);
`endif
    exp_drain = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h19};
    for (int k = 0; k < 8; k++) begin
      wait_valid("drain");
      check($sformatf("drain_%0d", k), tx_data, {24'h0, exp_drain[k]});
      tick();
    end
    for (int k = 0; k < 6; k++) tick();
    check("drain_empty", tx_valid, 32'h0);
    check("drain_not_full", buf_full, 32'h0);

    // Asynchronous reset mid-drain.
    tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(c_WRITE, c_IO, 8'(8'h31 + k));
      tick();
    end
    idle(); tick();
    check("pre_rst_valid", tx_valid, 32'h1);
    check("pre_rst_data", tx_data, 32'h31);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", tx_valid, 32'h0);
    check("async_rst_full", buf_full, 32'h0);
    check("async_rst_data", tx_data, 32'h0);
    check("async_rst_mem_dt", dt_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(c_READ, 32'h0000_0020, 8'h00); tick();
    check("ram_survives_rst", dt_out, 32'h77);
    tx_ready = 1'b1;
    idle();
    for (int k = 0; k < 4; k++) tick();
    check("rst_discard", tx_valid, 32'h0);
`ifdef MEM_IO_OVERFLOW_STAT_EN
    check("rst_ovf_clear", overflow, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the byte-wide memory bus driven by the memory controller.
- Holds a byte-addressed RAM and a memory-mapped output port at IO_ADDR.
- IO writes are buffered in a TX FIFO, which raises the IO-buffer-full flag that the controller uses to stall.
- Sits below the memory controller in the CPU top; the TX side feeds the UART/sim console.

Parameters:
- ADDR_WIDTH, 17, RAM address bits; depth is 2^ADDR_WIDTH bytes.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two and at least 4.
- IO_ADDR, 32'h0003_0000, byte address of the output port.
- DRAIN_DIV, 4, minimum number of cycles between successive TX pops; must be at least 1.

Ports:
- clk, in, 1, clock; everything is on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- rdy, in, 1, global ready; when low, the memory-side state freezes.
- iMEM_rw, in, 1, 0 = `Read, 1 = `Write (shared constants).
- iMEM_addr, in, 32, byte address.
- iMEM_dt, in, 8, write byte.
- oMEM_dt, out, 8, read byte, registered.
- oIO_buffer_full, out, 1, the TX FIFO is within one entry of full.
- oTX_valid, out, 1, the TX head byte is available.
- oTX_data, out, 8, the TX head byte.
- iTX_ready, in, 1, the consumer accepts the head byte.

Behaviour:
- Reset (rst_n low, asynchronous):
  - oMEM_dt = 0.
  - FIFO pointers and count = 0; oTX_valid = 0; oTX_data = 0.
  - Pacing counter = 0; oIO_buffer_full = 0.
  - RAM contents are not reset.
- Address decode:
  - is_io = (iMEM_addr == IO_ADDR).
  - Otherwise the RAM index is iMEM_addr[ADDR_WIDTH-1:0]; upper bits are ignored, so the address wraps.
- Read (rdy=1, rw=`Read):
  - oMEM_dt <= RAM[idx] on the same edge, so data is valid exactly 1 cycle after the address.
  - An IO read returns 8'h00.
- Write (rdy=1, rw=`Write):
  - RAM case: RAM[idx] <= iMEM_dt and oMEM_dt <= 0.
  - IO case: push iMEM_dt into the FIFO if count < FIFO_DEPTH; otherwise drop the byte. RAM is not touched.
- rdy=0: no RAM write, no push, and oMEM_dt holds its value.
- TX drain:
  - The drain runs regardless of rdy.
  - oTX_valid = (count != 0) && (pace == 0); oTX_data = FIFO[rd_ptr].
  - Pop on oTX_valid && iTX_ready. On a pop, pace <= DRAIN_DIV-1.
  - When pace != 0 it decrements by one each cycle.
- Count update:
  - Push only: +1. Pop only: -1.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
- oIO_buffer_full:
  - Registered, computed from the next count: set when next_count >= FIFO_DEPTH-1.
  - The one-entry headroom absorbs the store already in flight when the controller sees the flag.
- Full boundary: a push at count == FIFO_DEPTH with a simultaneous pop is accepted, because the pop frees the slot in the same cycle.
- Reset mid-drain: pending bytes are discarded.

Optional Feature:
- Macro MEM_IO_OVERFLOW_STAT_EN.
- Defined:
  - Adds oIO_overflow (1-bit, sticky) and oIO_drop_cnt (16-bit, saturating).
  - Both update on every dropped IO write and clear only on reset.
- Undefined: these ports are absent and dropped bytes leave no trace.

Decomposition:
- Shared package/config:
  - `Read/`Write encodings.
  - IO_ADDR default.
  - MemDataBus (8) and AddrBus (32) widths.
- One sub-module, tx_byte_fifo:
  - Parameterised by depth.
  - Provides push/pop, count, head data and full/almost-full outputs.
- The top block holds the RAM, decode and pacing counter.

Test Plan:
1. Write 8'hA5 to 0x00010, then read 0x00010 → oMEM_dt = 8'hA5 one cycle after the read address; oMEM_dt = 0 during the write cycle.
2. Write 8'h3C to 0x20010 with ADDR_WIDTH=17, then read 0x00010 → 8'h3C (wrap).
3. Write "H", "i" to 0x30000 with iTX_ready=1 and DRAIN_DIV=4 → oTX_data 8'h48, then 8'h69, pops 4 cycles apart; RAM[0x10000] is unchanged.
4. With iTX_ready=0, perform 7 IO writes → oIO_buffer_full rises in the cycle after the 7th push (count=7); the 8th write is accepted; a 9th write is dropped, and with MEM_IO_OVERFLOW_STAT_EN oIO_overflow=1 and oIO_drop_cnt=1.
5. At count=8 with pace=0, issue iTX_ready=1 and an IO write in the same cycle → count stays 8 and no drop occurs.
6. Deassert rst_n asynchronously mid-drain with count=3 → oTX_valid=0 and oIO_buffer_full=0 immediately; RAM data written before reset still reads back.
